wb_port_arbiter: RTL

//  Sequences the single register-file write port between the in-order pipeline write-back
//  (MEM/WB) and a multi-cycle unit (MDU: mul/div) whose results arrive out of band.

---
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_port_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back, MDU result and register-file port bundle
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                     pipe_we;
  logic [4:0]               pipe_rd;
  logic [31:0]              pipe_wdata;
  logic                     mdu_valid;
  logic                     mdu_ready;
  logic [4:0]               mdu_rd;
  logic [31:0]              mdu_wdata;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [31:0]              rf_wdata;
  logic                     rf_src;
  logic                     stall_req;
  logic [31:0]              pend_mask;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, pipeline first, MDU results queued
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_port_arbiter_if.slave     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic [31:0]   mask;

  logic pipe_active;
  logic fifo_empty;
  logic push;
  logic pop;

  assign pipe_active    = bus.pipe_we & (bus.pipe_rd != 5'd0);
  assign fifo_empty     = (count == '0);
  assign bus.mdu_ready  = (count < CW'(DEPTH)) & rst_n;
  // x0 results are acknowledged but never stored
  assign push           = bus.mdu_valid & bus.mdu_ready & (bus.mdu_rd != 5'd0);
  assign pop            = ~pipe_active & ~fifo_empty;
  assign bus.fifo_count = count;
  assign bus.pend_mask  = mask;

  always_comb begin
    starve_next = '0;
    if (!fifo_empty && !pop) begin
      starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        mask[fifo_rd[rd_ptr + PW'(k)]] = 1'b1;
      end
    end
    mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      starve_cnt    <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= 5'd0;
      bus.rf_wdata  <= 32'd0;
      bus.rf_src    <= 1'b0;
      bus.stall_req <= 1'b0;
    end else begin
      if (pipe_active) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.pipe_rd;
        bus.rf_wdata <= bus.pipe_wdata;
        bus.rf_src   <= 1'b0;
      end else if (pop) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= fifo_rd[rd_ptr];
        bus.rf_wdata <= fifo_data[rd_ptr];
        bus.rf_src   <= 1'b1;
      end else begin
        bus.rf_we    <= 1'b0;
      end

      if (push) begin
        fifo_rd[wr_ptr]   <= bus.mdu_rd;
        fifo_data[wr_ptr] <= bus.mdu_wdata;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      starve_cnt    <= starve_next;
      bus.stall_req <= (starve_next == SW'(STARVE_LIMIT));
    end
  end
endmodule
